// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative multiply/divide unit with HI/LO result registers
//
// Executes mult (alu_ctrl 4'b1010) and div (alu_ctrl 4'b1111), one bit per cycle,
// as a shift-add multiplier and a restoring divider.
// Optional feature macro: MULDIV_SIGNED_EN (honours signed_op when defined).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        operation request, sampled only while busy=0
//   alu_ctrl     4-bit ALU control code
//   signed_op    two's-complement operands (MULDIV_SIGNED_EN builds only)
//   a, b         multiplicand/dividend, multiplier/divisor
//   busy         operation in flight
//   done         one-cycle pulse when hi/lo update
//   hi, lo       mult: product halves; div: remainder, quotient
//   div_by_zero  set with done for a div by zero, cleared on next accepted start
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] CTRL_MUL = 4'b1010;
    localparam logic [3:0] CTRL_DIV = 4'b1111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    // mult: {partial product, remaining multiplier bits}; div: {rem, quot}
    logic [2*WIDTH-1:0] acc;
    // mult: multiplicand magnitude; div: divisor magnitude
    logic [WIDTH-1:0]   opnd;
    logic               dz;

    logic               accept;
    logic               is_div_req;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign is_div_req = (alu_ctrl == CTRL_DIV);
    assign accept     = start && (state == IDLE) && ((alu_ctrl == CTRL_MUL) || is_div_req);

`ifdef MULDIV_SIGNED_EN
    logic sa, sb;
    logic neg_lo, neg_hi, is_div;
    assign sa    = signed_op & a[WIDTH-1];
    assign sb    = signed_op & b[WIDTH-1];
    assign a_mag = sa ? -a : a;
    assign b_mag = sb ? -b : b;
`else
    logic unused_signed;
    assign unused_signed = signed_op;
    assign a_mag = a;
    assign b_mag = b;
`endif

    // One multiplier step: conditionally add multiplicand into the upper half.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    // One restoring-divider step. rem < divisor always holds, so WIDTH+1 bits
    // suffice and diff[WIDTH] is the borrow (negative trial result).
    assign rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, opnd};

    always_comb begin
        fix_hi = acc[2*WIDTH-1:WIDTH];
        fix_lo = acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        // Divide-by-zero leaves raw {a, all-ones} in acc, so no correction.
        if (!dz) begin
            if (is_div) begin
                if (neg_lo) fix_lo = -acc[WIDTH-1:0];
                if (neg_hi) fix_hi = -acc[2*WIDTH-1:WIDTH];
            end else if (neg_lo) begin
                {fix_hi, fix_lo} = -acc;
            end
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = is_div_req ? ((b == '0) ? FIX : DIV) : MUL;
            MUL:  if (cnt == CW'(1)) state_next = FIX;
            DIV:  if (cnt == CW'(1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            dz          <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            is_div      <= 1'b0;
`endif
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == FIX);
            case (state)
                IDLE: if (accept) begin
                    cnt         <= CW'(WIDTH);
                    div_by_zero <= 1'b0;
                    dz          <= is_div_req && (b == '0);
`ifdef MULDIV_SIGNED_EN
                    is_div      <= is_div_req;
                    neg_lo      <= sa ^ sb;
                    neg_hi      <= sa;
`endif
                    if (is_div_req && (b == '0)) begin
                        acc <= {a, {WIDTH{1'b1}}};
                    end else if (is_div_req) begin
                        opnd <= b_mag;
                        acc  <= {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        opnd <= a_mag;
                        acc  <= {{WIDTH{1'b0}}, b_mag};
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt - CW'(1);
                end
                DIV: begin
                    if (diff[WIDTH]) acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    else             acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq
module tb_alu_muldiv_seq;
    localparam int W = 32;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1111;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   alu_ctrl;
    logic         signed_op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
        .signed_op(signed_op), .a(a), .b(b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   ctrl;
        logic         sgn;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] c, logic s, logic [W-1:0] va, logic [W-1:0] vb,
                                logic [W-1:0] eh, logic [W-1:0] el, logic ed, int lt);
        vec_t v;
        v.ctrl = c; v.sgn = s; v.a = va; v.b = vb;
        v.hi = eh; v.lo = el; v.dz = ed; v.lat = lt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands as the instruction defines it.
    task automatic ref_op(input logic [3:0] c, input logic s_in, input logic [W-1:0] x,
                          input logic [W-1:0] y, output logic [W-1:0] eh,
                          output logic [W-1:0] el, output logic ed);
        logic s;
        longint          ps;
        longint unsigned pu;
`ifdef MULDIV_SIGNED_EN
        s = s_in;
`else
        s = 1'b0 & s_in;
`endif
        ed = 1'b0;
        if (c == OP_MUL) begin
            if (s) begin
                ps = longint'($signed(x)) * longint'($signed(y));
                {eh, el} = ps;
            end else begin
                pu = 64'(x) * 64'(y);
                {eh, el} = pu;
            end
        end else if (y == 0) begin
            eh = x; el = '1; ed = 1'b1;
        end else if (s) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                el = x; eh = 0;
            end else begin
                el = $signed(x) / $signed(y);
                eh = $signed(x) % $signed(y);
            end
        end else begin
            el = x / y;
            eh = x % y;
        end
    endtask

    // Issue one op at the next falling edge (back-to-back if called in a done cycle)
    // and wait for done. poke_at >= 0 raises a spurious start mid-operation.
    task automatic run_op(input logic [3:0] c, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int poke_at,
                          output logic [W-1:0] gh, output logic [W-1:0] gl,
                          output logic gdz, output int lat, output logic hs_ok);
        @(negedge clk);
        start = 1'b1; alu_ctrl = c; signed_op = s; a = x; b = y;
        @(posedge clk); #1;
        hs_ok = (busy === 1'b1) && (done === 1'b0) && (div_by_zero === 1'b0);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == poke_at) begin
                start = 1'b1; alu_ctrl = OP_DIV; a = 32'd9; b = 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) hs_ok = 1'b0;
        end
        if (busy !== 1'b0) hs_ok = 1'b0;
        gh = hi; gl = lo; gdz = div_by_zero;
    endtask

    task automatic check_op(input string tag, input logic [3:0] c, input logic s,
                            input logic [W-1:0] x, input logic [W-1:0] y, input int poke_at);
        logic [W-1:0] gh, gl, eh, el;
        logic gdz, ed, hs;
        int lat;
        ref_op(c, s, x, y, eh, el, ed);
        run_op(c, s, x, y, poke_at, gh, gl, gdz, lat, hs);
        chk({tag, ".hi"}, 64'(gh), 64'(eh));
        chk({tag, ".lo"}, 64'(gl), 64'(el));
        chk({tag, ".dz"}, 64'(gdz), 64'(ed));
        chk({tag, ".lat"}, 64'(lat), (c == OP_DIV && y == 0) ? 64'd1 : 64'(W + 1));
        chk({tag, ".handshake"}, 64'(hs), 64'd1);
    endtask

    initial begin
        logic [W-1:0] gh, gl, ra, rb, save_hi, save_lo;
        logic gdz, hs;
        int lat, r;

        rst = 1'b1; start = 1'b0; alu_ctrl = 4'b0; signed_op = 1'b0; a = '0; b = '0;

        vecs.push_back(mk(OP_MUL, 0, 7, 6, 0, 42, 0, W + 1));
`ifdef MULDIV_SIGNED_EN
        vecs.push_back(mk(OP_MUL, 1, 32'hFFFF_FFFD, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, W + 1));
`endif
        vecs.push_back(mk(OP_DIV, 0, 100, 7, 2, 14, 0, W + 1));
`ifdef MULDIV_SIGNED_EN
        vecs.push_back(mk(OP_DIV, 1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, W + 1));
        vecs.push_back(mk(OP_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0, W + 1));
        vecs.push_back(mk(OP_DIV, 1, 7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 0, W + 1));
`endif
        vecs.push_back(mk(OP_DIV, 0, 123, 0, 123, 32'hFFFF_FFFF, 1, 1));
        vecs.push_back(mk(OP_MUL, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, W + 1));
        vecs.push_back(mk(OP_DIV, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, W + 1));
        vecs.push_back(mk(OP_DIV, 0, 5, 10, 5, 0, 0, W + 1));

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("reset.busy", 64'(busy), 0);
        chk("reset.done", 64'(done), 0);
        chk("reset.hi", 64'(hi), 0);
        chk("reset.lo", 64'(lo), 0);
        chk("reset.dz", 64'(div_by_zero), 0);

        // Table vectors, issued back-to-back.
        foreach (vecs[i]) begin
            run_op(vecs[i].ctrl, vecs[i].sgn, vecs[i].a, vecs[i].b, -1, gh, gl, gdz, lat, hs);
            chk($sformatf("vec%0d.hi", i), 64'(gh), 64'(vecs[i].hi));
            chk($sformatf("vec%0d.lo", i), 64'(gl), 64'(vecs[i].lo));
            chk($sformatf("vec%0d.dz", i), 64'(gdz), 64'(vecs[i].dz));
            chk($sformatf("vec%0d.lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d.handshake", i), 64'(hs), 1);
        end

        // Invalid control code: nothing starts, results hold.
        save_hi = hi; save_lo = lo;
        @(negedge clk);
        start = 1'b1; alu_ctrl = 4'b0010; a = 32'd11; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        hs = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) hs = 1'b0;
        end
        chk("invalid.idle", 64'(hs), 1);
        chk("invalid.hi_hold", 64'(hi), 64'(save_hi));
        chk("invalid.lo_hold", 64'(lo), 64'(save_lo));

        // Start pulse during a running mult is ignored.
        check_op("poke", OP_MUL, 1'b0, 32'd7, 32'd6, 5);

        // Reset 10 cycles into a div aborts it immediately.
        @(negedge clk);
        start = 1'b1; alu_ctrl = OP_DIV; signed_op = 1'b0; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.busy", 64'(busy), 0);
        chk("abort.hi", 64'(hi), 0);
        chk("abort.lo", 64'(lo), 0);
        hs = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0) hs = 1'b0;
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) hs = 1'b0;
        end
        chk("abort.no_done", 64'(hs), 1);
        check_op("after_abort", OP_MUL, 1'b0, 32'd7, 32'd6, -1);

        // Randomized ops against the reference model.
        for (int n = 0; n < 150; n++) begin
            r  = $urandom_range(0, 9);
            ra = $urandom;
            rb = $urandom;
            if (r == 0) rb = 0;
            else if (r <= 3) rb = $urandom_range(1, 15);
            else if (r == 4) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            check_op($sformatf("rand%0d", n), ($urandom_range(0, 1) == 1) ? OP_DIV : OP_MUL,
                     1'($urandom_range(0, 1)), ra, rb, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
